// File: rtl/waveform_pkg.sv
// Shared definitions for the waveform capture block: default geometry,
// address width, FSM state encoding and the trigger rule.
package waveform_pkg;

  localparam int unsigned WAVE_DEPTH = 640;
  localparam int unsigned WAVE_DW    = 12;
  localparam int unsigned WAVE_AW    = 10;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Rising crossing of the threshold between two consecutive accepted samples.
  function automatic logic rising_cross(input int unsigned cur,
                                        input int unsigned prev,
                                        input int unsigned level);
    return (cur >= level) && (prev < level);
  endfunction

endpackage

// File: rtl/wave_dpram.sv
// Simple dual-port RAM: one write port, one registered read port whose
// output register can be synchronously cleared instead of loaded.
module wave_dpram #(
  parameter int unsigned WORDS = 1280,
  parameter int unsigned DW    = 12,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_clr_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [WORDS];
  logic [DW-1:0] rd_data_q;

  // Storage array has no reset so it maps onto a RAM macro.
  always_ff @(posedge clk) begin : p_write
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_read
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_clr_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/waveform_capture.sv
// Rising-edge triggered single-trace recorder with ping-pong banks swapped at frame_start.
// Define WAVE_CAPTURE_DECIM_EN to store only every DECIM-th sample during CAPTURE.
module waveform_capture
  import waveform_pkg::*;
#(
  parameter int unsigned   DEPTH      = WAVE_DEPTH,
  parameter int unsigned   DW         = WAVE_DW,
  parameter logic [DW-1:0] TRIG_LEVEL = DW'(12'd2048),
  parameter int unsigned   DECIM      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  input  logic [DW-1:0]      s_data,
  output logic               s_ready,
  input  logic               frame_start,
  input  logic [WAVE_AW-1:0] rd_addr,
  output logic [DW-1:0]      rd_data,
  output logic               rd_valid,
  output logic [1:0]         state
);

  localparam int unsigned        RAM_WORDS  = 2 * DEPTH;
  localparam int unsigned        RAM_AW     = $clog2(RAM_WORDS);
  localparam logic [WAVE_AW-1:0] LAST_ADDR  = WAVE_AW'(DEPTH - 1);
  localparam logic [RAM_AW-1:0]  BANK1_BASE = RAM_AW'(DEPTH);

  if (DECIM == 0) begin : g_decim_chk
    $error("waveform_capture: DECIM must be at least 1");
  end

  if (DEPTH > (1 << WAVE_AW)) begin : g_depth_chk
    $error("waveform_capture: DEPTH exceeds the write address range");
  end

  state_t               state_q, state_d;
  logic                 bank_sel_q, bank_sel_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 s_ready_q, s_ready_d;
  logic [WAVE_AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]        prev_q;

  logic                 accept_c;
  logic                 trig_c;
  logic                 keep_c;
  logic                 last_c;
  logic                 wr_en_c;
  logic                 rd_oob_c;
  logic [RAM_AW-1:0]    ram_waddr_c;
  logic [RAM_AW-1:0]    ram_raddr_c;

  assign accept_c = s_valid & s_ready_q;
  assign trig_c   = accept_c & rising_cross(32'(s_data), 32'(prev_q), 32'(TRIG_LEVEL));
  assign last_c   = (waddr_q == LAST_ADDR);

`ifdef WAVE_CAPTURE_DECIM_EN
  localparam int unsigned DCW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [DCW-1:0] dec_q, dec_d;

  // Phase counter: the trigger sample is phase 0, every DECIM-th sample after it is kept.
  always_comb begin : p_decim
    dec_d = dec_q;
    if (state_q == ARMED && trig_c) begin
      dec_d = (DECIM > 1) ? DCW'(1) : '0;
    end else if (state_q == CAPTURE && accept_c) begin
      dec_d = (32'(dec_q) >= DECIM - 1) ? '0 : dec_q + DCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_decim_reg
    if (!rst_n) begin
      dec_q <= '0;
    end else begin
      dec_q <= dec_d;
    end
  end

  assign keep_c = (dec_q == '0);
`else
  assign keep_c = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin : p_state_reg
    if (!rst_n) begin
      state_q <= ARMED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : p_next_state
    state_d = state_q;
    case (state_q)
      ARMED:   if (trig_c) state_d = last_c ? DONE : CAPTURE;
      CAPTURE: if (accept_c && keep_c && last_c) state_d = DONE;
      DONE:    if (frame_start) state_d = ARMED;
      default: state_d = ARMED;
    endcase
  end

  // frame_start only matters in DONE, so a trace finishing this cycle waits for the next one.
  always_comb begin : p_outputs
    wr_en_c    = 1'b0;
    bank_sel_d = bank_sel_q;
    rd_valid_d = rd_valid_q;
    waddr_d    = waddr_q;
    s_ready_d  = (state_d != DONE);
    case (state_q)
      ARMED:   wr_en_c = trig_c;
      CAPTURE: wr_en_c = accept_c & keep_c;
      DONE: begin
        if (frame_start) begin
          bank_sel_d = ~bank_sel_q;
          rd_valid_d = 1'b1;
        end
      end
      default: wr_en_c = 1'b0;
    endcase
    if (state_d == ARMED) begin
      waddr_d = '0;
    end else if (wr_en_c && !last_c) begin
      waddr_d = waddr_q + WAVE_AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_regs
    if (!rst_n) begin
      bank_sel_q <= 1'b0;
      rd_valid_q <= 1'b0;
      s_ready_q  <= 1'b0;
      waddr_q    <= '0;
      prev_q     <= '1;
    end else begin
      bank_sel_q <= bank_sel_d;
      rd_valid_q <= rd_valid_d;
      s_ready_q  <= s_ready_d;
      waddr_q    <= waddr_d;
      if (accept_c) begin
        prev_q <= s_data;
      end
    end
  end

  // Bank 0 occupies words [0, DEPTH), bank 1 occupies [DEPTH, 2*DEPTH).
  assign ram_waddr_c = RAM_AW'(waddr_q) + (bank_sel_q ? BANK1_BASE : '0);
  assign ram_raddr_c = RAM_AW'(rd_addr) + (bank_sel_q ? '0 : BANK1_BASE);
  assign rd_oob_c    = (32'(rd_addr) >= DEPTH);

  wave_dpram #(
    .WORDS (RAM_WORDS),
    .DW    (DW),
    .AW    (RAM_AW)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en_c),
    .wr_addr_i (ram_waddr_c),
    .wr_data_i (s_data),
    .rd_clr_i  (rd_oob_c),
    .rd_addr_i (ram_raddr_c),
    .rd_data_o (rd_data)
  );

  assign s_ready  = s_ready_q;
  assign rd_valid = rd_valid_q;
  assign state    = state_q;

endmodule

// File: tb/tb_waveform_capture.sv
// Self-checking bench for waveform_capture: random and ramp sample streams checked
// against a trace model derived from the stream (first rising crossing, then fixed stride).
module tb_waveform_capture;

  localparam int DEPTH = 640;
  localparam int DW    = 12;
  localparam int TRIG  = 2048;
`ifdef WAVE_CAPTURE_DECIM_EN
  localparam int STEP  = 4;
`else
  localparam int STEP  = 1;
`endif
  localparam int SPAN  = STEP * (DEPTH - 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          frame_start;
  logic [9:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [1:0]    state;

  int vectors = 0;
  int errors  = 0;

  int stream[$];
  int exp_mem[2][DEPTH];
  bit bank_ok[2];
  bit m_sel;
  bit m_rdv;
  bit m_done;
  int m_prev;

  waveform_capture #(
    .DEPTH      (DEPTH),
    .DW         (DW),
    .TRIG_LEVEL (12'd2048),
    .DECIM      (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .frame_start (frame_start),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int find_trig(input int p0);
    int p = p0;
    for (int j = 0; j < stream.size(); j++) begin
      if (stream[j] >= TRIG && p < TRIG) return j;
      p = stream[j];
    end
    return -1;
  endfunction

  function automatic int exp_rd(input int a);
    if (a >= DEPTH) return 0;
    return exp_mem[m_sel ? 0 : 1][a];
  endfunction

  function automatic bit disp_known(input int a);
    return (a >= DEPTH) || bank_ok[m_sel ? 0 : 1];
  endfunction

  task automatic gen_random(output int idx);
    int p;
    int v;
    stream.delete();
    p   = m_prev;
    idx = -1;
    while (idx < 0) begin
      v = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, TRIG - 1)) : int'($urandom_range(0, 4095));
      if (v >= TRIG && p < TRIG) idx = stream.size();
      stream.push_back(v);
      p = v;
    end
    repeat (SPAN) stream.push_back(int'($urandom_range(0, 4095)));
  endtask

  task automatic drive_range(input int first, input int last, input int fs_idx,
                             input bit gaps, output int stalls);
    stalls = 0;
    for (int j = first; j <= last; j++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick();
      if (s_ready !== 1'b1) stalls++;
      s_valid     = 1'b1;
      s_data      = 12'(stream[j]);
      frame_start = (j == fs_idx);
      tick();
      s_valid     = 1'b0;
      frame_start = 1'b0;
    end
    if (last >= first) m_prev = stream[last];
  endtask

  task automatic commit(input int idx);
    for (int k = 0; k < DEPTH; k++) exp_mem[m_sel][k] = stream[idx + k * STEP];
    bank_ok[m_sel] = 1'b1;
    m_done = 1'b1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (m_done) begin
      m_sel  = !m_sel;
      m_rdv  = 1'b1;
      m_done = 1'b0;
    end
  endtask

  task automatic read_word(input int a, output logic [DW-1:0] obs);
    rd_addr = 10'(a);
    tick();
    obs = rd_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; frame_start = 1'b0; rd_addr = '0;
    repeat (3) tick();
    vectors++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    vectors++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
    vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    vectors++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data); end
    rst_n = 1'b1;
    m_sel = 1'b0; m_rdv = 1'b0; m_done = 1'b0; m_prev = 4095;
    bank_ok[0] = 1'b0; bank_ok[1] = 1'b0;
    repeat (2) tick();
    vectors++; if (s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready: got %b expected 1", s_ready); end
  endtask

  task automatic test_constant();
    int idx;
    int stalls;
    stream.delete();
    repeat (50) stream.push_back(3000);
    idx = find_trig(m_prev);
    drive_range(0, 49, -1, 1'b1, stalls);
    vectors++; if (stalls !== 0) begin errors++; $display("FAIL const_stalls: got %0d expected 0", stalls); end
    vectors++; if (state !== ((idx < 0) ? 2'd0 : 2'd1)) begin errors++; $display("FAIL const_state: got %0d expected 0", state); end
    vectors++; if (rd_valid !== m_rdv) begin errors++; $display("FAIL const_rd_valid: got %b expected %b", rd_valid, m_rdv); end
  endtask

  task automatic test_ramp();
    int idx;
    int stalls;
    logic [DW-1:0] obs;
    stream.delete();
    for (int j = 0; j <= 2048 + SPAN; j++) stream.push_back(j % 4096);
    idx = find_trig(m_prev);
    drive_range(0, idx + SPAN, -1, 1'b1, stalls);
    vectors++; if (stalls !== 0) begin errors++; $display("FAIL ramp_stalls: got %0d expected 0", stalls); end
    vectors++; if (state !== 2'd2) begin errors++; $display("FAIL ramp_done_state: got %0d expected 2", state); end
    vectors++; if (s_ready !== 1'b0) begin errors++; $display("FAIL ramp_done_ready: got %b expected 0", s_ready); end
    commit(idx);
    vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ramp_pre_swap_valid: got %b expected 0", rd_valid); end
    pulse_frame();
    vectors++; if (state !== 2'd0) begin errors++; $display("FAIL ramp_swap_state: got %0d expected 0", state); end
    vectors++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL ramp_swap_valid: got %b expected 1", rd_valid); end
    read_word(0, obs);
    vectors++; if (obs !== 12'd2048) begin errors++; $display("FAIL ramp_addr0: got %0d expected 2048", obs); end
    read_word(1, obs);
    vectors++; if (obs !== ((STEP == 4) ? 12'd2052 : 12'd2049)) begin errors++; $display("FAIL ramp_addr1: got %0d expected %0d", obs, (STEP == 4) ? 2052 : 2049); end
    read_word(639, obs);
    vectors++; if (obs !== ((STEP == 4) ? 12'd508 : 12'd2687)) begin errors++; $display("FAIL ramp_addr639: got %0d expected %0d", obs, (STEP == 4) ? 508 : 2687); end
    for (int a = 0; a < DEPTH; a++) begin
      read_word(a, obs);
      vectors++; if (obs !== 12'(exp_rd(a))) begin errors++; $display("FAIL ramp_trace[%0d]: got %0d expected %0d", a, obs, exp_rd(a)); end
    end
  endtask

  task automatic test_oob_read();
    int addrs[7] = '{700, 5, 640, 639, 1023, 0, 0};
    logic [DW-1:0] obs;
    addrs[6] = int'($urandom_range(DEPTH, 1023));
    foreach (addrs[i]) begin
      read_word(addrs[i], obs);
      vectors++; if (obs !== 12'(exp_rd(addrs[i]))) begin errors++; $display("FAIL oob_read[%0d]: got %0d expected %0d", addrs[i], obs, exp_rd(addrs[i])); end
    end
  endtask

  task automatic test_frame_start();
    int idx;
    int stalls;
    int a;
    logic [DW-1:0] obs;
    pulse_frame();
    vectors++; if (state !== 2'd0) begin errors++; $display("FAIL fs_armed_state: got %0d expected 0", state); end
    vectors++; if (rd_valid !== m_rdv) begin errors++; $display("FAIL fs_armed_valid: got %b expected %b", rd_valid, m_rdv); end
    read_word(0, obs);
    vectors++; if (obs !== 12'(exp_rd(0))) begin errors++; $display("FAIL fs_armed_read: got %0d expected %0d", obs, exp_rd(0)); end
    gen_random(idx);
    drive_range(0, idx + 50, -1, 1'b1, stalls);
    drive_range(idx + 51, idx + 51, idx + 51, 1'b0, stalls);
    vectors++; if (state !== 2'd1) begin errors++; $display("FAIL fs_capture_state: got %0d expected 1", state); end
    vectors++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL fs_capture_valid: got %b expected 1", rd_valid); end
    repeat (8) begin
      a = int'($urandom_range(0, DEPTH - 1));
      read_word(a, obs);
      vectors++; if (obs !== 12'(exp_rd(a))) begin errors++; $display("FAIL fs_capture_read[%0d]: got %0d expected %0d", a, obs, exp_rd(a)); end
    end
    drive_range(idx + 52, idx + SPAN, idx + SPAN, 1'b1, stalls);
    vectors++; if (stalls !== 0) begin errors++; $display("FAIL fs_stalls: got %0d expected 0", stalls); end
    vectors++; if (state !== 2'd2) begin errors++; $display("FAIL fs_last_state: got %0d expected 2", state); end
    commit(idx);
    repeat (8) begin
      a = int'($urandom_range(0, DEPTH - 1));
      read_word(a, obs);
      vectors++; if (obs !== 12'(exp_rd(a))) begin errors++; $display("FAIL fs_done_read[%0d]: got %0d expected %0d", a, obs, exp_rd(a)); end
    end
    pulse_frame();
    vectors++; if (state !== 2'd0) begin errors++; $display("FAIL fs_swap_state: got %0d expected 0", state); end
    for (int k = 0; k < DEPTH; k++) begin
      read_word(k, obs);
      vectors++; if (obs !== 12'(exp_rd(k))) begin errors++; $display("FAIL fs_trace[%0d]: got %0d expected %0d", k, obs, exp_rd(k)); end
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    int stalls;
    logic [DW-1:0] obs;
    repeat (2) begin
      gen_random(idx);
      drive_range(0, idx + SPAN, -1, 1'b1, stalls);
      vectors++; if (stalls !== 0) begin errors++; $display("FAIL b2b_stalls: got %0d expected 0", stalls); end
      vectors++; if (state !== 2'd2) begin errors++; $display("FAIL b2b_done_state: got %0d expected 2", state); end
      s_valid = 1'b1;
      s_data  = '0;
      repeat (2) begin
        vectors++; if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_ready: got %b expected 0", s_ready); end
        tick();
      end
      s_valid = 1'b0;
      commit(idx);
      pulse_frame();
      vectors++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", rd_valid); end
      for (int k = 0; k < DEPTH; k++) begin
        read_word(k, obs);
        vectors++; if (obs !== 12'(exp_rd(k))) begin errors++; $display("FAIL b2b_trace[%0d]: got %0d expected %0d", k, obs, exp_rd(k)); end
      end
    end
  endtask

  task automatic test_reset_mid_capture();
    int idx;
    int stalls;
    int a;
    logic [DW-1:0] obs;
    gen_random(idx);
    drive_range(0, idx + STEP * 299, -1, 1'b1, stalls);
    vectors++; if (state !== 2'd1) begin errors++; $display("FAIL mid_capture_state: got %0d expected 1", state); end
    rst_n = 1'b0;
    #2;
    vectors++; if (state !== 2'd0) begin errors++; $display("FAIL mid_reset_state: got %0d expected 0", state); end
    vectors++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b expected 0", s_ready); end
    vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", rd_valid); end
    vectors++; if (rd_data !== '0) begin errors++; $display("FAIL mid_reset_rd_data: got %0d expected 0", rd_data); end
    bank_ok[m_sel] = 1'b0;
    m_sel = 1'b0; m_rdv = 1'b0; m_done = 1'b0; m_prev = 4095;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    vectors++; if (state !== 2'd0) begin errors++; $display("FAIL mid_release_state: got %0d expected 0", state); end
    vectors++; if (s_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready: got %b expected 1", s_ready); end
    vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_release_valid: got %b expected 0", rd_valid); end
    repeat (8) begin
      a = int'($urandom_range(0, DEPTH - 1));
      read_word(a, obs);
      if (disp_known(a)) begin
        vectors++; if (obs !== 12'(exp_rd(a))) begin errors++; $display("FAIL mid_ram_kept[%0d]: got %0d expected %0d", a, obs, exp_rd(a)); end
      end
    end
    gen_random(idx);
    drive_range(0, idx + SPAN, -1, 1'b1, stalls);
    vectors++; if (state !== 2'd2) begin errors++; $display("FAIL mid_recapture_state: got %0d expected 2", state); end
    commit(idx);
    pulse_frame();
    vectors++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL mid_recapture_valid: got %b expected 1", rd_valid); end
    for (int k = 0; k < DEPTH; k++) begin
      read_word(k, obs);
      vectors++; if (obs !== 12'(exp_rd(k))) begin errors++; $display("FAIL mid_trace[%0d]: got %0d expected %0d", k, obs, exp_rd(k)); end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_oob_read();
    test_frame_start();
    test_back_to_back();
    test_reset_mid_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
